// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline perf counters with auto-stop and valid/ready dump of four totals
// Optional: define PERF_CNT_SATURATE_EN for saturating counters (default wraps).

module pipe_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             retire_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] out_data_o,
    output logic [1:0]       out_idx_o,
    output logic             running_o,
    output logic             done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_t;

    // Run length is tracked separately so the stop point is exact even when
    // the visible cycle counter wraps or saturates.
    localparam int LIM_W = $clog2(CYCLE_LIMIT + 2);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_n [4];
    logic [LIM_W-1:0] lim_q, lim_n;
    logic [1:0]       idx_q, idx_n;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
`ifdef PERF_CNT_SATURATE_EN
        return (en && (c != '1)) ? c + 1'b1 : c;
`else
        return en ? c + 1'b1 : c;
`endif
    endfunction

    always_comb begin
        state_n = state_q;
        lim_n   = lim_q;
        idx_n   = idx_q;
        for (int i = 0; i < 4; i++) cnt_n[i] = cnt_q[i];
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start_i) begin
                    cnt_n[0] = bump(cnt_q[0], 1'b1);
                    cnt_n[1] = bump(cnt_q[1], stall_i && !branch_i);
                    cnt_n[2] = bump(cnt_q[2], flush_i);
                    cnt_n[3] = bump(cnt_q[3], retire_i);
                    lim_n    = lim_q + 1'b1;
                    if ((CYCLE_LIMIT != 0) && (lim_n == LIM_W'(CYCLE_LIMIT)))
                        state_n = S_DUMP;
                    else
                        state_n = S_RUN;
                end
            end
            S_DUMP: begin
                if (out_valid_o && out_ready_i) begin
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they change only on clock edges.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            lim_q       <= '0;
            idx_q       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_n;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_n[i];
            lim_q       <= lim_n;
            idx_q       <= idx_n;
            out_valid_o <= (state_n == S_DUMP);
            out_data_o  <= (state_n == S_DUMP) ? cnt_n[idx_n] : '0;
            running_o   <= (state_n == S_RUN);
            done_o      <= (state_n == S_DONE);
        end
    end

    assign out_idx_o = idx_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - randomized bench for pipe_perf_monitor against an event-count model

module tb_pipe_perf_monitor;

    localparam int LIM_A = 10;
    localparam int LIM_B = 20;
`ifdef PERF_CNT_SATURATE_EN
    localparam longint B_EXP = 15;
`else
    localparam longint B_EXP = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 0, stall_a = 0, branch_a = 0, flush_a = 0, retire_a = 0, ready_a = 0;
    logic valid_a, running_a, done_a;
    logic [31:0] data_a;
    logic [1:0]  idx_a;

    logic start_b = 1, stall_b = 0, branch_b = 0, flush_b = 0, retire_b = 1, ready_b = 0;
    logic valid_b, running_b, done_b;
    logic [3:0]  data_b;
    logic [1:0]  idx_b;

    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(LIM_A)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .stall_i(stall_a), .branch_i(branch_a),
        .flush_i(flush_a), .retire_i(retire_a), .out_valid_o(valid_a), .out_ready_i(ready_a),
        .out_data_o(data_a), .out_idx_o(idx_a), .running_o(running_a), .done_o(done_a));

    pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(LIM_B)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .stall_i(stall_b), .branch_i(branch_b),
        .flush_i(flush_b), .retire_i(retire_b), .out_valid_o(valid_b), .out_ready_i(ready_b),
        .out_data_o(data_b), .out_idx_o(idx_b), .running_o(running_b), .done_o(done_b));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: phase 0 idle, 1 run, 2 dump, 3 done; true (unbounded) event totals.
    typedef struct {
        int     phase;
        int     idx;
        longint e0, e1, e2, e3;
    } mdl_t;

    function automatic mdl_t mzero();
        mdl_t r;
        r.phase = 0; r.idx = 0; r.e0 = 0; r.e1 = 0; r.e2 = 0; r.e3 = 0;
        return r;
    endfunction

    function automatic longint mev(input mdl_t m, input int i);
        case (i)
            0: return m.e0;
            1: return m.e1;
            2: return m.e2;
            default: return m.e3;
        endcase
    endfunction

    function automatic longint wv(input longint v, input int w);
        longint full;
        full = (longint'(1) << w) - 1;
`ifdef PERF_CNT_SATURATE_EN
        return (v > full) ? full : v;
`else
        return v & full;
`endif
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input logic st, input logic sl, input logic br,
                                   input logic fl, input logic rt, input logic rd, input int lim);
        mdl_t r = s;
        if ((s.phase == 0 || s.phase == 1) && st) begin
            r.e0 = s.e0 + 1;
            r.e1 = s.e1 + ((sl && !br) ? 1 : 0);
            r.e2 = s.e2 + (fl ? 1 : 0);
            r.e3 = s.e3 + (rt ? 1 : 0);
            r.phase = (lim != 0 && r.e0 == lim) ? 2 : 1;
        end else if (s.phase == 2 && rd) begin
            if (s.idx == 3) r.phase = 3;
            else r.idx = s.idx + 1;
        end
        return r;
    endfunction

    mdl_t ma, mb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mzero();
            mb <= mzero();
        end else begin
            ma <= mstep(ma, start_a, stall_a, branch_a, flush_a, retire_a, ready_a, LIM_A);
            mb <= mstep(mb, start_b, stall_b, branch_b, flush_b, retire_b, ready_b, LIM_B);
        end
    end

    task automatic cmp(input string t, input mdl_t m, input logic v, input logic [1:0] ix,
                       input longint d, input logic rn, input logic dn, input int w);
        chk({t, "_valid"}, v, m.phase == 2);
        chk({t, "_running"}, rn, m.phase == 1);
        chk({t, "_done"}, dn, m.phase == 3);
        if (v && m.phase == 2) begin
            chk({t, "_idx"}, ix, m.idx);
            chk({t, "_data"}, d, wv(mev(m, m.idx), w));
        end
    endtask

    longint cap_a [4];
    longint cap_b [4];
    int hs_a = 0;
    int first_idx_a = -1;

    initial begin
        forever begin
            @(negedge clk);
            cmp("a", ma, valid_a, idx_a, longint'(data_a), running_a, done_a, 32);
            cmp("b", mb, valid_b, idx_b, longint'(data_b), running_b, done_b, 4);
            if (!rst_n) begin
                hs_a = 0;
                first_idx_a = -1;
            end else begin
                if (valid_a && ready_a) begin
                    if (hs_a == 0) first_idx_a = idx_a;
                    cap_a[idx_a] = longint'(data_a);
                    hs_a++;
                end
                if (valid_b && ready_b) cap_b[idx_b] = longint'(data_b);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            stall_b  = 1'($urandom_range(0, 1));
            branch_b = 1'($urandom_range(0, 1));
            flush_b  = 1'($urandom_range(0, 1));
            ready_b  = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ev_a();
        stall_a  = 1'($urandom_range(0, 1));
        branch_a = 1'($urandom_range(0, 1));
        flush_a  = 1'($urandom_range(0, 1));
        retire_a = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done_a(input string name);
        int k = 0;
        while (!done_a && k < 300) begin
            rand_ev_a();
            ready_a = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk(name, done_a, 1);
    endtask

    initial begin
        int n;
        int k;
        // Reset values
        tick();
        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_running", running_a, 0);
        chk("rst_done", done_a, 0);
        rst_n = 1'b1;

        // Directed run: stalls 2..4 with branch on 3, flush 6, retire 5..9
        start_a = 1'b1;
        for (int c = 0; c < LIM_A; c++) begin
            stall_a  = (c >= 2 && c <= 4);
            branch_a = (c == 3);
            flush_a  = (c == 6);
            retire_a = (c >= 5 && c <= 9);
            tick();
        end
        stall_a = 0; branch_a = 0; flush_a = 0; retire_a = 0;
        chk("dir_valid_after_limit", valid_a, 1);
        chk("dir_first_idx", idx_a, 0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk("hold_valid", valid_a, 1);
            chk("hold_idx", idx_a, 1);
            chk("hold_data", data_a, 2);
        end
        ready_a = 1'b1;
        k = 0;
        while (!done_a && k < 20) begin
            tick();
            k++;
        end
        chk("dir_done", done_a, 1);
        chk("dir_cycles", cap_a[0], 10);
        chk("dir_stalls", cap_a[1], 2);
        chk("dir_flushes", cap_a[2], 1);
        chk("dir_retired", cap_a[3], 5);
        chk("dir_handshakes", hs_a, 4);

        // Narrow counters: retire always high for 20 cycles
        k = 0;
        while (!done_b && k < 300) begin
            tick();
            k++;
        end
        chk("b_done", done_b, 1);
        chk("b_cycles_word", cap_b[0], B_EXP);
        chk("b_retired_word", cap_b[3], B_EXP);

        // Pause for 5 cycles mid-run with events asserted
        do_reset();
        start_a = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            rand_ev_a();
            tick();
            n++;
        end
        start_a = 1'b0;
        stall_a = 1; flush_a = 1; retire_a = 1; branch_a = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n++;
            chk("pause_running", running_a, 1);
        end
        start_a = 1'b1;
        while (!valid_a && n < 200) begin
            rand_ev_a();
            tick();
            n++;
        end
        chk("pause_run_len", n, LIM_A + 5);
        wait_done_a("pause_done");
        chk("pause_cycles_word", cap_a[0], LIM_A);

        // Reset during dump at idx 2, then a fresh full run
        do_reset();
        start_a = 1'b1;
        k = 0;
        while (!(valid_a && idx_a == 2) && k < 300) begin
            rand_ev_a();
            ready_a = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("mid_reach_idx2", idx_a, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_data", data_a, 0);
        chk("mid_rst_idx", idx_a, 0);
        chk("mid_rst_running", running_a, 0);
        chk("mid_rst_done", done_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        start_a = 1'b1;
        wait_done_a("fresh_done");
        chk("fresh_first_idx", first_idx_a, 0);
        chk("fresh_handshakes", hs_a, 4);
        chk("fresh_cycles_word", cap_a[0], LIM_A);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
